// File: rtl/avmm_burst_ram_pipelined.sv
// Avalon-MM burst slave scratch memory: one burst in flight, configurable
// read latency, byte enables, optional wrapping bursts and zero-length bursts.
module avmm_burst_ram_pipelined #(
  parameter int WIDTHA       = 10,
  parameter int WIDTHD       = 32,
  parameter int WIDTHB       = 8,
  parameter int READ_LATENCY = 2,
  parameter int WRAP_BEATS   = 0
) (
  input  logic                  clock,
  input  logic                  clock_areset_n,
  input  logic [WIDTHA-1:0]     address,
  input  logic [WIDTHD-1:0]     writedata,
  input  logic [WIDTHD/8-1:0]   byteenable,
  input  logic [WIDTHB-1:0]     burstcount,
  input  logic                  read,
  input  logic                  write,
  output logic [WIDTHD-1:0]     readdata,
  output logic                  readdatavalid,
  output logic                  waitrequest
);

  localparam int BYTES = WIDTHD / 8;
  localparam int DEPTH = 2 ** WIDTHA;
  // Busy-cycle counter must hold READ_LATENCY + burstcount - 2
  localparam int CW    = WIDTHB + 4;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t              state;
  state_t              state_next;
  logic [WIDTHA-1:0]   base;
  logic [WIDTHB-1:0]   count;
  logic [WIDTHB-1:0]   offset;
  logic [CW-1:0]       busy_left;
  logic [CW-1:0]       rd_busy_init;

  logic                wr_en;
  logic [WIDTHA-1:0]   wr_addr;
  logic                issue_vld;
  logic [WIDTHA-1:0]   issue_addr;

  logic [WIDTHD-1:0]   mem [DEPTH];
  logic [WIDTHD-1:0]   data_p [READ_LATENCY];
  logic [READ_LATENCY-1:0] vld_p;

  // Word address of a beat: linear with wrap at top of memory, or wrapped
  // inside the WRAP_BEATS-aligned window that holds the base address.
  function automatic logic [WIDTHA-1:0] beat_addr(input logic [WIDTHA-1:0] b,
                                                  input logic [WIDTHB-1:0] o);
    logic [WIDTHA-1:0] sum;
    logic [WIDTHA-1:0] mask;
    sum  = b + WIDTHA'(o);
    mask = WIDTHA'(WRAP_BEATS - 1);
    if (WRAP_BEATS == 0) return sum;
    return (b & ~mask) | (sum & mask);
  endfunction

  // Cycles that waitrequest stays high after a read of burstcount beats is
  // accepted: it must fall in the cycle of the final readdatavalid.
  assign rd_busy_init = CW'(READ_LATENCY) + CW'(burstcount) - CW'(2);

  // State register
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) state <= IDLE;
    else                 state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (write) begin
          if (burstcount > WIDTHB'(1)) state_next = WRITE;
        end else if (read && burstcount != '0) begin
          if (rd_busy_init != '0)
            state_next = (burstcount == WIDTHB'(1)) ? DRAIN : READ;
        end
      end
      WRITE: if (write && offset == count - 1'b1) state_next = IDLE;
      READ: begin
        if (offset == count - 1'b1)
          state_next = (busy_left == CW'(1)) ? IDLE : DRAIN;
      end
      DRAIN: if (busy_left == CW'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs and datapath strobes. Beat 0 of a read is looked up on the
  // acceptance edge itself so that a latency of one cycle is reachable;
  // READ then issues the remaining offsets one per cycle.
  always_comb begin
    waitrequest = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = address;
    issue_vld   = 1'b0;
    issue_addr  = address;
    case (state)
      IDLE: begin
        if (write)     wr_en     = clock_areset_n && (burstcount != '0);
        else if (read) issue_vld = (burstcount != '0);
      end
      WRITE: begin
        wr_en   = clock_areset_n && write;
        wr_addr = beat_addr(base, offset);
      end
      READ: begin
        waitrequest = 1'b1;
        issue_vld   = 1'b1;
        issue_addr  = beat_addr(base, offset);
      end
      DRAIN: waitrequest = 1'b1;
      default: waitrequest = 1'b0;
    endcase
  end

  // Burst bookkeeping: base, length, beat offset and busy countdown
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      base      <= '0;
      count     <= '0;
      offset    <= '0;
      busy_left <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write || read) begin
            base   <= address;
            count  <= burstcount;
            offset <= WIDTHB'(1);
          end
          if (!write && read) busy_left <= rd_busy_init;
        end
        WRITE: if (write) offset <= offset + 1'b1;
        READ: begin
          offset    <= offset + 1'b1;
          busy_left <= busy_left - 1'b1;
        end
        DRAIN: busy_left <= busy_left - 1'b1;
        default: busy_left <= busy_left;
      endcase
    end
  end

  // Memory array with per-byte write enables; contents survive reset
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < BYTES; b++)
        if (byteenable[b]) mem[wr_addr][b*8 +: 8] <= writedata[b*8 +: 8];
    end
  end

  // Read latency pipeline: stage 0 is the array lookup, later stages delay
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      vld_p <= '0;
      for (int i = 0; i < READ_LATENCY; i++) data_p[i] <= '0;
    end else begin
      vld_p[0]  <= issue_vld;
      data_p[0] <= mem[issue_addr];
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_p[i]  <= vld_p[i-1];
        data_p[i] <= data_p[i-1];
      end
    end
  end

  assign readdata      = data_p[READ_LATENCY-1];
  assign readdatavalid = vld_p[READ_LATENCY-1];

endmodule

// File: tb/tb_avmm_burst_ram_pipelined.sv
// Bench for avmm_burst_ram_pipelined: three instances (latency 2 linear,
// latency 1 wrap-4, latency 8 linear) driven with shared commands and checked
// every cycle against a cycle-indexed expectation table built from a word model.
module tb_avmm_burst_ram_pipelined;
  localparam int NC = 16384;
  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [7:0]  burstcount = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;

  logic [31:0] rdata [ND];
  logic        rdv [ND];
  logic        wreq [ND];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic cmp_on = 1'b0;

  logic        exp_vld  [ND][NC];
  logic [31:0] exp_data [ND][NC];
  logic        exp_wr   [ND][NC];
  logic [31:0] mm [ND][1024];
  logic [31:0] wd [256];
  logic [3:0]  wbe [256];
  int          wst [256];

  avmm_burst_ram_pipelined #(.READ_LATENCY(2), .WRAP_BEATS(0)) dut_a (
    .clock(clk), .clock_areset_n(rst_n), .address(address), .writedata(writedata),
    .byteenable(byteenable), .burstcount(burstcount), .read(read), .write(write),
    .readdata(rdata[0]), .readdatavalid(rdv[0]), .waitrequest(wreq[0]));
  avmm_burst_ram_pipelined #(.READ_LATENCY(1), .WRAP_BEATS(4)) dut_b (
    .clock(clk), .clock_areset_n(rst_n), .address(address), .writedata(writedata),
    .byteenable(byteenable), .burstcount(burstcount), .read(read), .write(write),
    .readdata(rdata[1]), .readdatavalid(rdv[1]), .waitrequest(wreq[1]));
  avmm_burst_ram_pipelined #(.READ_LATENCY(8), .WRAP_BEATS(0)) dut_c (
    .clock(clk), .clock_areset_n(rst_n), .address(address), .writedata(writedata),
    .byteenable(byteenable), .burstcount(burstcount), .read(read), .write(write),
    .readdata(rdata[2]), .readdatavalid(rdv[2]), .waitrequest(wreq[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rl_of(input int d);
    if (d == 0) return 2;
    if (d == 1) return 1;
    return 8;
  endfunction

  function automatic int wrap_of(input int d);
    return (d == 1) ? 4 : 0;
  endfunction

  // Word address of beat k for instance d
  function automatic int maddr(input int d, input int b, input int k);
    int n;
    n = wrap_of(d);
    if (n == 0) return (b + k) % 1024;
    return (b / n) * n + ((b % n) + k) % n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mwrite(input int d, input int a, input logic [31:0] data, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) mm[d][a][b*8 +: 8] = data[b*8 +: 8];
  endtask

  // A read accepted in cycle t: beat k valid at t+RL+k, busy t+1..t+RL+bc-2
  task automatic model_read(input int t, input int a, input int bc);
    for (int d = 0; d < ND; d++) begin
      for (int k = 0; k < bc; k++) begin
        if (t + rl_of(d) + k < NC) begin
          exp_vld[d][t + rl_of(d) + k]  = 1'b1;
          exp_data[d][t + rl_of(d) + k] = mm[d][maddr(d, a, k)];
        end
      end
      for (int c = t + 1; c <= t + rl_of(d) + bc - 2; c++)
        if (bc > 0 && c < NC) exp_wr[d][c] = 1'b1;
    end
  endtask

  // Per-cycle compare against the expectation table
  always @(negedge clk) begin
    if (cmp_on && cyc < NC) begin
      for (int d = 0; d < ND; d++) begin
        chk($sformatf("d%0d_valid@%0d", d, cyc), 32'(rdv[d]), 32'(exp_vld[d][cyc]));
        chk($sformatf("d%0d_waitreq@%0d", d, cyc), 32'(wreq[d]), 32'(exp_wr[d][cyc]));
        if (exp_vld[d][cyc])
          chk($sformatf("d%0d_data@%0d", d, cyc), rdata[d], exp_data[d][cyc]);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((wreq[0] | wreq[1] | wreq[2]) !== 1'b0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 64) begin
      errors++;
      $display("FAIL idle_timeout: waitrequest still high after %0d cycles, required low", n);
    end
  endtask

  task automatic do_read(input int a, input int bc);
    wait_idle();
    address = 10'(a); burstcount = 8'(bc); read = 1'b1; write = 1'b0;
    model_read(cyc, a, bc);
    @(negedge clk);
    read = 1'b0; address = 10'($urandom); burstcount = 8'($urandom);
  endtask

  task automatic do_write(input int a, input int bc, input logic with_read);
    int nb;
    wait_idle();
    nb = (bc == 0) ? 1 : bc;
    for (int k = 0; k < nb; k++) begin
      if (k > 0) begin
        for (int s = 0; s < wst[k]; s++) begin
          write = 1'b0; read = 1'($urandom_range(0, 1));
          writedata = $urandom; byteenable = 4'($urandom);
          @(negedge clk);
        end
      end
      write = 1'b1;
      read = (k == 0) ? with_read : 1'b0;
      address = (k == 0) ? 10'(a) : 10'($urandom);
      burstcount = (k == 0) ? 8'(bc) : 8'($urandom);
      writedata = wd[k]; byteenable = wbe[k];
      if (bc != 0)
        for (int d = 0; d < ND; d++) mwrite(d, maddr(d, a, k), wd[k], wbe[k]);
      @(negedge clk);
    end
    write = 1'b0; read = 1'b0;
  endtask

  task automatic fill(input int n, input logic full_be, input int maxstall);
    for (int k = 0; k < n; k++) begin
      wd[k] = $urandom;
      wbe[k] = full_be ? 4'hF : 4'($urandom);
      wst[k] = $urandom_range(0, maxstall);
    end
  endtask

  function automatic int rand_base();
    if ($urandom_range(0, 1) == 0) return $urandom_range(0, 'h30);
    return $urandom_range('h3F0, 'h3FF);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int t;
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < NC; c++) begin
        exp_vld[d][c] = 1'b0; exp_wr[d][c] = 1'b0; exp_data[d][c] = '0;
      end
      for (int a = 0; a < 1024; a++) mm[d][a] = '0;
    end
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("reset_valid_d%0d", d), 32'(rdv[d]), 32'd0);
      chk($sformatf("reset_waitreq_d%0d", d), 32'(wreq[d]), 32'd0);
      chk($sformatf("reset_data_d%0d", d), rdata[d], 32'd0);
    end
    cmp_on = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Known contents for the regions the bench reads
    for (int b = 0; b < 'h40; b += 4) begin fill(4, 1'b1, 0); do_write(b, 4, 1'b0); end
    for (int b = 'h3F0; b < 'h400; b += 4) begin fill(4, 1'b1, 0); do_write(b, 4, 1'b0); end

    // Linear write then read of four beats with literal timing
    for (int k = 0; k < 4; k++) begin wd[k] = 32'hA0 + k; wbe[k] = 4'hF; wst[k] = 0; end
    do_write('h10, 4, 1'b0);
    chk("model_pin_0x12", mm[0]['h12], 32'h000000A2);
    wait_idle();
    t = cyc;
    address = 10'h010; burstcount = 8'd4; read = 1'b1;
    model_read(t, 'h10, 4);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      read = 1'b0;
      chk($sformatf("lin_waitreq_t%0d", i), 32'(wreq[0]), (i <= 4) ? 32'd1 : 32'd0);
      if (i >= 2) chk($sformatf("lin_data_t%0d", i), rdata[0], 32'hA0 + 32'(i - 2));
    end

    // Stalled write with byte enables
    wd[0] = 32'h11223344; wbe[0] = 4'hF; wst[0] = 0;
    do_write('h20, 1, 1'b0);
    wd[0] = 32'hFFFFFFFF; wbe[0] = 4'b0011;
    wd[1] = 32'hDEADBEEF; wbe[1] = 4'hF; wst[1] = 3;
    do_write('h20, 2, 1'b0);
    chk("model_pin_be", mm[0]['h20], 32'h1122FFFF);
    chk("model_pin_beat1", mm[2]['h21], 32'hDEADBEEF);
    do_read('h20, 2);

    // Wrap and top-of-memory bursts
    chk("model_pin_wrap", 32'(maddr(1, 6, 2)), 32'h4);
    chk("model_pin_top_lin", 32'(maddr(0, 'h3FE, 2)), 32'h0);
    chk("model_pin_top_wrap", 32'(maddr(1, 'h3FE, 2)), 32'h3FC);
    do_read(6, 4);
    do_read('h3FE, 3);

    // Zero-length read followed immediately by another command; zero-length write
    do_read('h10, 0);
    do_read('h11, 1);
    wd[0] = 32'h12345678; wbe[0] = 4'hF;
    do_write('h30, 1, 1'b0);
    wd[0] = 32'h55555555; wbe[0] = 4'hF;
    do_write('h30, 0, 1'b0);
    chk("model_pin_zero_write", mm[0]['h30], 32'h12345678);
    do_read('h30, 1);

    // Asynchronous reset in the middle of an eight-beat read
    wait_idle();
    t = cyc;
    address = 10'h000; burstcount = 8'd8; read = 1'b1;
    model_read(t, 0, 8);
    @(negedge clk);
    read = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    for (int d = 0; d < ND; d++)
      for (int c = cyc; c < NC; c++) begin exp_vld[d][c] = 1'b0; exp_wr[d][c] = 1'b0; end
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("midrst_valid_d%0d", d), 32'(rdv[d]), 32'd0);
      chk($sformatf("midrst_waitreq_d%0d", d), 32'(wreq[d]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_read(0, 8);

    // Single-beat latency on the latency-1 and latency-8 instances
    wait_idle();
    t = cyc;
    address = 10'h013; burstcount = 8'd1; read = 1'b1;
    model_read(t, 'h13, 1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      read = 1'b0;
      chk($sformatf("lat1_valid_t%0d", i), 32'(rdv[1]), (i == 1) ? 32'd1 : 32'd0);
      chk($sformatf("lat8_valid_t%0d", i), 32'(rdv[2]), (i == 8) ? 32'd1 : 32'd0);
      if (i == 1) chk("lat1_data", rdata[1], 32'hA3);
      if (i == 8) chk("lat8_data", rdata[2], 32'hA3);
    end

    // Read and write together in IDLE: only the write happens
    wd[0] = 32'hCAFEF00D; wbe[0] = 4'hF;
    do_write('h14, 1, 1'b1);
    chk("model_pin_rw", mm[0]['h14], 32'hCAFEF00D);
    do_read('h14, 1);

    // Randomised traffic
    for (int n = 0; n < 200; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        fill(8, 1'b0, 3);
        do_write(rand_base(), $urandom_range(0, 6), 1'b0);
      end else if (op <= 8) begin
        do_read(rand_base(), $urandom_range(0, 8));
      end else begin
        fill(8, 1'b0, 2);
        do_write(rand_base(), $urandom_range(0, 3), 1'b1);
      end
    end

    wait_idle();
    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
